// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand-select codes and stall FSM states.
package hazard_forward_unit_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Remaining-stall counter width; holds up to 3 cycles.
   localparam int unsigned STALL_N_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } stall_state_e;

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// Saturating event counter with synchronous reset, clear and hold.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             hold,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (!hold && inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects for EX and ID operands plus load-use/branch hazard stall control
// with saturating hazard statistics for the debug unit.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int unsigned REG_AW        = 5,
   parameter int unsigned ZERO_REG_HW   = 1,
   parameter int unsigned BR_LOAD_STALL = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_halt,
   input  logic [REG_AW-1:0] i_rs_ifid,
   input  logic [REG_AW-1:0] i_rt_ifid,
   input  logic              i_branch_id,
   input  logic [REG_AW-1:0] i_rs_idex,
   input  logic [REG_AW-1:0] i_rt_idex,
   input  logic [REG_AW-1:0] i_dst_idex,
   input  logic              i_regwrite_idex,
   input  logic              i_memread_idex,
   input  logic [REG_AW-1:0] i_dst_exmem,
   input  logic              i_regwrite_exmem,
   input  logic              i_memread_exmem,
   input  logic [REG_AW-1:0] i_dst_memwb,
   input  logic              i_regwrite_memwb,
   input  logic              i_cnt_clr,
   output logic [1:0]        o_fwd_a_ex,
   output logic [1:0]        o_fwd_b_ex,
   output logic [1:0]        o_fwd_a_id,
   output logic [1:0]        o_fwd_b_id,
   output logic              o_stall_pc,
   output logic              o_stall_ifid,
   output logic              o_flush_idex,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_lu_cnt,
   output logic [CNT_W-1:0]  o_br_cnt
);

   localparam logic [STALL_N_W-1:0] BR_LOAD_N = STALL_N_W'(BR_LOAD_STALL);

   function automatic logic match(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst,
                                  input logic              we);
      return we && (src == dst) && !((ZERO_REG_HW != 0) && (dst == '0));
   endfunction

   function automatic logic [1:0] ex_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] d_em,
                                         input logic              we_em,
                                         input logic [REG_AW-1:0] d_mw,
                                         input logic              we_mw);
      if (match(src, d_em, we_em)) return FWD_EXMEM;
      if (match(src, d_mw, we_mw)) return FWD_MEMWB;
      return FWD_RF;
   endfunction

   // A load still in MEM has no data yet for the comparator; that case stalls instead.
   function automatic logic [1:0] id_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] d_em,
                                         input logic              we_em,
                                         input logic              ld_em,
                                         input logic [REG_AW-1:0] d_mw,
                                         input logic              we_mw);
      if (!ld_em && match(src, d_em, we_em)) return FWD_EXMEM;
      if (match(src, d_mw, we_mw)) return FWD_MEMWB;
      return FWD_RF;
   endfunction

   assign o_fwd_a_ex = ex_sel(i_rs_idex, i_dst_exmem, i_regwrite_exmem, i_dst_memwb, i_regwrite_memwb);
   assign o_fwd_b_ex = ex_sel(i_rt_idex, i_dst_exmem, i_regwrite_exmem, i_dst_memwb, i_regwrite_memwb);
   assign o_fwd_a_id = id_sel(i_rs_ifid, i_dst_exmem, i_regwrite_exmem, i_memread_exmem,
                              i_dst_memwb, i_regwrite_memwb);
   assign o_fwd_b_id = id_sel(i_rt_ifid, i_dst_exmem, i_regwrite_exmem, i_memread_exmem,
                              i_dst_memwb, i_regwrite_memwb);

   logic lu_hit, br_alu_hit, br_ldex_hit, br_ldmem_hit, br_event;
   logic [STALL_N_W-1:0] hazard_n;

   assign lu_hit       = i_memread_idex &&
                         (match(i_rs_ifid, i_dst_idex, 1'b1) || match(i_rt_ifid, i_dst_idex, 1'b1));
   assign br_alu_hit   = i_branch_id && !i_memread_idex &&
                         (match(i_rs_ifid, i_dst_idex, i_regwrite_idex) ||
                          match(i_rt_ifid, i_dst_idex, i_regwrite_idex));
   assign br_ldex_hit  = i_branch_id && lu_hit;
   assign br_ldmem_hit = i_branch_id && i_memread_exmem &&
                         (match(i_rs_ifid, i_dst_exmem, i_regwrite_exmem) ||
                          match(i_rt_ifid, i_dst_exmem, i_regwrite_exmem));
   assign br_event     = br_alu_hit || br_ldex_hit || br_ldmem_hit;

   // Largest required stall among all active hazard sources.
   always_comb begin
      hazard_n = '0;
      if (lu_hit || br_alu_hit || br_ldmem_hit) hazard_n = STALL_N_W'(1);
      if (br_ldex_hit && (BR_LOAD_N > hazard_n)) hazard_n = BR_LOAD_N;
   end

   stall_state_e         state, state_next;
   logic [STALL_N_W-1:0] rem, rem_next;
   logic                 count_event;
   logic                 stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
      end
   end

   always_comb begin
      state_next  = state;
      rem_next    = rem;
      count_event = 1'b0;
      if (!i_halt) begin
         case (state)
            IDLE: begin
               if (hazard_n != '0) begin
                  count_event = 1'b1;
                  if (hazard_n > STALL_N_W'(1)) begin
                     rem_next   = hazard_n - STALL_N_W'(1);
                     state_next = STALL;
                  end
               end
            end
            STALL: begin
               if (rem <= STALL_N_W'(1)) begin
                  rem_next   = '0;
                  state_next = IDLE;
               end else begin
                  rem_next = rem - STALL_N_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Live detection is always ORed in so a hazard seen mid-stall is never missed.
   assign stall        = ((state == STALL) && !reset) || (hazard_n != '0);
   assign o_stall_pc   = stall || i_halt;
   assign o_stall_ifid = stall || i_halt;
   assign o_flush_idex = stall && !i_halt;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .clr(i_cnt_clr), .hold(i_halt),
      .inc(stall), .count(o_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
      .clk(clk), .reset(reset), .clr(i_cnt_clr), .hold(i_halt),
      .inc(count_event && !br_event), .count(o_lu_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk(clk), .reset(reset), .clr(i_cnt_clr), .hold(i_halt),
      .inc(count_event && br_event), .count(o_br_cnt)
   );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scenario bench for hazard_forward_unit: each step queues expected outputs/counters,
// captures the DUT response, and each scenario task checks its own queue entries.
module tb_hazard_forward_unit;
   import hazard_forward_unit_pkg::*;

   localparam logic [1:0]  RF = FWD_RF;
   localparam logic [1:0]  EM = FWD_EXMEM;
   localparam logic [1:0]  MW = FWD_MEMWB;
   localparam logic [10:0] QUIET   = 11'b0;
   localparam logic [10:0] STALLED = 11'b111;

   typedef struct packed {
      logic       rst, halt, clr, branch;
      logic [4:0] rs_ifid, rt_ifid, rs_idex, rt_idex, dst_idex;
      logic       rw_idex, mr_idex;
      logic [4:0] dst_exmem;
      logic       rw_exmem, mr_exmem;
      logic [4:0] dst_memwb;
      logic       rw_memwb;
   } stim_t;

   logic        clk, reset, i_halt, i_branch_id, i_cnt_clr;
   logic [4:0]  i_rs_ifid, i_rt_ifid, i_rs_idex, i_rt_idex, i_dst_idex, i_dst_exmem, i_dst_memwb;
   logic        i_regwrite_idex, i_memread_idex, i_regwrite_exmem, i_memread_exmem, i_regwrite_memwb;
   logic [1:0]  o_fwd_a_ex, o_fwd_b_ex, o_fwd_a_id, o_fwd_b_id;
   logic        o_stall_pc, o_stall_ifid, o_flush_idex;
   logic [15:0] o_stall_cnt, o_lu_cnt, o_br_cnt;

   logic [10:0] exp_o_q[$], obs_o_q[$];
   logic [47:0] exp_c_q[$], obs_c_q[$];
   int passed = 0;
   int total  = 0;

   hazard_forward_unit dut (
      .clk(clk), .reset(reset), .i_halt(i_halt),
      .i_rs_ifid(i_rs_ifid), .i_rt_ifid(i_rt_ifid), .i_branch_id(i_branch_id),
      .i_rs_idex(i_rs_idex), .i_rt_idex(i_rt_idex), .i_dst_idex(i_dst_idex),
      .i_regwrite_idex(i_regwrite_idex), .i_memread_idex(i_memread_idex),
      .i_dst_exmem(i_dst_exmem), .i_regwrite_exmem(i_regwrite_exmem),
      .i_memread_exmem(i_memread_exmem),
      .i_dst_memwb(i_dst_memwb), .i_regwrite_memwb(i_regwrite_memwb),
      .i_cnt_clr(i_cnt_clr),
      .o_fwd_a_ex(o_fwd_a_ex), .o_fwd_b_ex(o_fwd_b_ex),
      .o_fwd_a_id(o_fwd_a_id), .o_fwd_b_id(o_fwd_b_id),
      .o_stall_pc(o_stall_pc), .o_stall_ifid(o_stall_ifid), .o_flush_idex(o_flush_idex),
      .o_stall_cnt(o_stall_cnt), .o_lu_cnt(o_lu_cnt), .o_br_cnt(o_br_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] eo(input logic [1:0] aex, input logic [1:0] bex,
                                      input logic [1:0] aid, input logic [1:0] bid,
                                      input logic pc, input logic fl);
      return {aex, bex, aid, bid, pc, pc, fl};
   endfunction

   function automatic logic [47:0] ec(input int s, input int l, input int b);
      return {16'(s), 16'(l), 16'(b)};
   endfunction

   // Drive one pipeline cycle, queue its expectations and capture what the DUT produced.
   task automatic apply(input stim_t s, input logic [10:0] eo_v, input logic [47:0] ec_v);
      @(negedge clk);
      reset = s.rst; i_halt = s.halt; i_cnt_clr = s.clr; i_branch_id = s.branch;
      i_rs_ifid = s.rs_ifid; i_rt_ifid = s.rt_ifid;
      i_rs_idex = s.rs_idex; i_rt_idex = s.rt_idex; i_dst_idex = s.dst_idex;
      i_regwrite_idex = s.rw_idex; i_memread_idex = s.mr_idex;
      i_dst_exmem = s.dst_exmem; i_regwrite_exmem = s.rw_exmem; i_memread_exmem = s.mr_exmem;
      i_dst_memwb = s.dst_memwb; i_regwrite_memwb = s.rw_memwb;
      exp_o_q.push_back(eo_v);
      exp_c_q.push_back(ec_v);
      #1;
      obs_o_q.push_back({o_fwd_a_ex, o_fwd_b_ex, o_fwd_a_id, o_fwd_b_id,
                         o_stall_pc, o_stall_ifid, o_flush_idex});
      @(posedge clk);
      #1;
      obs_c_q.push_back({o_stall_cnt, o_lu_cnt, o_br_cnt});
   endtask

   task automatic test_reset();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.rst = 1'b1;
      apply(s, QUIET, ec(0, 0, 0));
      s = '0;
      apply(s, QUIET, ec(0, 0, 0));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL reset step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL reset step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_ex_forward();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.rs_idex = 5'd9; s.dst_exmem = 5'd9; s.rw_exmem = 1'b1;
      s.dst_memwb = 5'd9; s.rw_memwb = 1'b1;
      apply(s, eo(EM, RF, RF, RF, 1'b0, 1'b0), ec(0, 0, 0));
      s.rw_exmem = 1'b0;
      apply(s, eo(MW, RF, RF, RF, 1'b0, 1'b0), ec(0, 0, 0));
      s = '0; s.rs_idex = 5'd4; s.rt_idex = 5'd0; s.dst_exmem = 5'd0; s.rw_exmem = 1'b1;
      apply(s, QUIET, ec(0, 0, 0));
      s = '0; s.rs_idex = 5'd3; s.rt_idex = 5'd7; s.rs_ifid = 5'd3; s.rt_ifid = 5'd7;
      s.dst_exmem = 5'd3; s.rw_exmem = 1'b1; s.dst_memwb = 5'd7; s.rw_memwb = 1'b1;
      apply(s, eo(EM, MW, EM, MW, 1'b0, 1'b0), ec(0, 0, 0));
      s.mr_exmem = 1'b1;
      apply(s, eo(EM, MW, RF, MW, 1'b0, 1'b0), ec(0, 0, 0));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL ex_forward step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL ex_forward step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_load_use();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd8;
      s.rs_ifid = 5'd8; s.rt_ifid = 5'd3;
      apply(s, STALLED, ec(1, 1, 0));
      s = '0; s.rs_ifid = 5'd8; s.rt_ifid = 5'd3;
      s.dst_exmem = 5'd8; s.rw_exmem = 1'b1; s.mr_exmem = 1'b1;
      apply(s, QUIET, ec(1, 1, 0));
      s = '0; s.rs_idex = 5'd8; s.rt_idex = 5'd3; s.dst_memwb = 5'd8; s.rw_memwb = 1'b1;
      apply(s, eo(MW, RF, RF, RF, 1'b0, 1'b0), ec(1, 1, 0));
      s = '0; s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd5;
      s.rs_ifid = 5'd1; s.rt_ifid = 5'd5;
      apply(s, STALLED, ec(2, 2, 0));
      s = '0;
      apply(s, QUIET, ec(2, 2, 0));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL load_use step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL load_use step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_branch_load();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8;
      s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd8;
      apply(s, STALLED, ec(3, 2, 1));
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8;
      s.dst_exmem = 5'd8; s.rw_exmem = 1'b1; s.mr_exmem = 1'b1;
      apply(s, STALLED, ec(4, 2, 1));
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8; s.dst_memwb = 5'd8; s.rw_memwb = 1'b1;
      apply(s, eo(RF, RF, MW, RF, 1'b0, 1'b0), ec(4, 2, 1));
      s = '0; s.branch = 1'b1; s.rt_ifid = 5'd6; s.dst_idex = 5'd6; s.rw_idex = 1'b1;
      apply(s, STALLED, ec(5, 2, 2));
      s = '0; s.branch = 1'b1; s.rt_ifid = 5'd6; s.dst_exmem = 5'd6; s.rw_exmem = 1'b1;
      apply(s, eo(RF, RF, RF, EM, 1'b0, 1'b0), ec(5, 2, 2));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL branch_load step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL branch_load step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_halt();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8;
      s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd8;
      apply(s, STALLED, ec(6, 2, 3));
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8; s.halt = 1'b1;
      s.dst_exmem = 5'd8; s.rw_exmem = 1'b1; s.mr_exmem = 1'b1;
      apply(s, eo(RF, RF, RF, RF, 1'b1, 1'b0), ec(6, 2, 3));
      s.halt = 1'b0;
      apply(s, STALLED, ec(7, 2, 3));
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8; s.dst_memwb = 5'd8; s.rw_memwb = 1'b1;
      apply(s, eo(RF, RF, MW, RF, 1'b0, 1'b0), ec(7, 2, 3));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL halt step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL halt step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8;
      s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd8;
      apply(s, STALLED, ec(8, 2, 4));
      s = '0; s.rst = 1'b1;
      apply(s, QUIET, ec(0, 0, 0));
      s = '0;
      apply(s, QUIET, ec(0, 0, 0));
      s = '0; s.branch = 1'b1; s.rs_ifid = 5'd8;
      s.dst_exmem = 5'd8; s.rw_exmem = 1'b1; s.mr_exmem = 1'b1;
      apply(s, STALLED, ec(1, 0, 1));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL reset_mid_stall step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL reset_mid_stall step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   task automatic test_saturation();
      stim_t s;
      logic [10:0] e1, o1;
      logic [47:0] e2, o2;
      int n = 0;
      s = '0; s.mr_idex = 1'b1; s.rw_idex = 1'b1; s.dst_idex = 5'd8; s.rs_ifid = 5'd8;
      s.clr = 1'b1;
      apply(s, STALLED, ec(0, 0, 0));
      @(negedge clk);
      i_cnt_clr = 1'b0;
      repeat (65534) @(posedge clk);
      s.clr = 1'b0;
      apply(s, STALLED, ec(16'hFFFF, 16'hFFFF, 0));
      apply(s, STALLED, ec(16'hFFFF, 16'hFFFF, 0));
      s.clr = 1'b1;
      apply(s, STALLED, ec(0, 0, 0));
      while (exp_o_q.size() != 0) begin
         e1 = exp_o_q.pop_front(); o1 = obs_o_q.pop_front();
         e2 = exp_c_q.pop_front(); o2 = obs_c_q.pop_front();
         total++;
         if (o1 !== e1) $display("FAIL saturation step %0d outputs: got %h expected %h", n, o1, e1);
         else passed++;
         total++;
         if (o2 !== e2) $display("FAIL saturation step %0d counters: got %h expected %h", n, o2, e2);
         else passed++;
         n++;
      end
   endtask

   initial begin
      reset = 1'b1; i_halt = 1'b0; i_cnt_clr = 1'b0; i_branch_id = 1'b0;
      i_rs_ifid = '0; i_rt_ifid = '0; i_rs_idex = '0; i_rt_idex = '0; i_dst_idex = '0;
      i_regwrite_idex = 1'b0; i_memread_idex = 1'b0;
      i_dst_exmem = '0; i_regwrite_exmem = 1'b0; i_memread_exmem = 1'b0;
      i_dst_memwb = '0; i_regwrite_memwb = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_ex_forward();
      test_load_use();
      test_branch_load();
      test_halt();
      test_reset_mid_stall();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
